ahb_log_acc: RTL and testbench

AHB_LOG_ACC -- requirements
Module: ahb_log_acc

---
 rtl/ahb_log_acc_if.sv | 22 ++
 rtl/ahb_log_acc.sv | 168 ++++++++++++++++
 tb/tb_ahb_log_acc.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_log_acc_if.sv
// AHB-lite slave-side bus bundle for the log-accumulator block.
interface ahb_log_acc_if;
  logic        hsel;
  logic        hready_i;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready_o;
  logic        hresp;

  modport slave (
    input  hsel, hready_i, hwrite, htrans, haddr, hwdata,
    output hrdata, hready_o, hresp
  );

  modport master (
    output hsel, hready_i, hwrite, htrans, haddr, hwdata,
    input  hrdata, hready_o, hresp
  );
endinterface

// File: rtl/ahb_log_acc.sv
// AHB-lite slave converting float32 samples to fixed-point log2 and
// accumulating them per channel with signed saturation.
module ahb_log_acc #(
  parameter int NCH   = 4,
  parameter int FRAC  = 16,
  parameter int ACC_W = 32
) (
  input  logic         hclk,
  input  logic         rst_n,
  ahb_log_acc_if.slave bus
);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SUM_W = ((ACC_W > 32) ? ACC_W : 32) + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  function automatic logic signed [31:0] log2_fix(input logic [31:0] f);
    logic signed [31:0] e_s;
    logic [22:0]        m_s;
    e_s = $signed({24'd0, f[30:23]}) - 32'sd127;
    m_s = f[22:0] >> (23 - FRAC);
    return (e_s <<< FRAC) + $signed({9'd0, m_s});
  endfunction

  function automatic logic is_bad(input logic [31:0] f);
    return f[31] | (f[30:23] == 8'h00) | (f[30:23] == 8'hFF);
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [31:0]      b);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > ACC_MAX) s = ACC_MAX;
    else if (s < ACC_MIN) s = ACC_MIN;
    return s[ACC_W-1:0];
  endfunction

  logic                    dp_valid_q, dp_write_q;
  logic [7:0]              dp_idx_q;
  logic                    hready_o_q;
  logic [31:0]             hrdata_q;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_bad_q, s1_bad_d;
  logic [CH_W-1:0]         s1_ch_q, s1_ch_d;
  logic signed [31:0]      s1_log_q, s1_log_d;
  logic signed [ACC_W-1:0] acc_q [NCH];
  logic signed [ACC_W-1:0] acc_d [NCH];
  logic [15:0]             cnt_q [NCH];
  logic [15:0]             cnt_d [NCH];
  logic [NCH-1:0]          err_q, err_d;

  logic        addr_ok_s, wr_s, clr_s, data_wr_s;
  logic        rd_start_s, slow_s, wait_s, in_wait_s, rd_load_s, rd_ch_ok_s;
  logic [7:0]  rd_idx_s;
  logic [CH_W-1:0] rd_ch_s;
  logic [31:0] rd_val_s, status_s;
  logic signed [SUM_W-1:0] acc_ext_s;
  logic        unused_s;

  assign unused_s  = ^{bus.haddr[31:10], bus.haddr[1:0], bus.htrans[0]};
  assign addr_ok_s = bus.hsel & bus.hready_i & bus.htrans[1];
  assign wr_s      = dp_valid_q & dp_write_q & hready_o_q;
  assign clr_s     = wr_s & (dp_idx_q == 8'h00) & bus.hwdata[0];
  assign data_wr_s = wr_s & (dp_idx_q[7:6] == 2'b01) & ({2'b00, dp_idx_q[5:0]} < 8'(NCH));

  // Stage 1 loads the decoded sample; clear and a DATA write never share a data phase.
  always_comb begin
    s1_valid_d = data_wr_s;
    s1_bad_d   = is_bad(bus.hwdata);
    s1_log_d   = log2_fix(bus.hwdata);
    s1_ch_d    = dp_idx_q[CH_W-1:0];
  end

  // Stage 2: saturating accumulate or sticky error; clear overrides both.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr_s) begin
      for (int i = 0; i < NCH; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = 16'd0;
      end
      err_d = '0;
    end else if (s1_valid_q) begin
      if (s1_bad_q) begin
        err_d[s1_ch_q] = 1'b1;
      end else begin
        acc_d[s1_ch_q] = sat_add(acc_q[s1_ch_q], s1_log_q);
        cnt_d[s1_ch_q] = (cnt_q[s1_ch_q] == 16'hFFFF) ? 16'hFFFF : cnt_q[s1_ch_q] + 16'd1;
      end
    end else begin
      err_d = err_q;
    end
  end

  // Read scheduling: a result-register read that lands behind a live stage 1 waits one cycle.
  always_comb begin
    rd_start_s = addr_ok_s & ~bus.hwrite;
    slow_s     = (bus.haddr[9:2] == 8'h01) | bus.haddr[9];
    wait_s     = rd_start_s & slow_s & s1_valid_d;
    in_wait_s  = ~hready_o_q & dp_valid_q & ~dp_write_q;
    rd_load_s  = in_wait_s | (rd_start_s & ~wait_s);
    rd_idx_s   = in_wait_s ? dp_idx_q : bus.haddr[9:2];
  end

  // Read mux looks at next-state values so the registered data is post-update.
  always_comb begin
    rd_ch_s    = rd_idx_s[CH_W-1:0];
    rd_ch_ok_s = ({2'b00, rd_idx_s[5:0]} < 8'(NCH));
    status_s   = 32'd0;
    status_s[16 +: NCH] = err_d;
    status_s[0] = s1_valid_d;
    acc_ext_s  = SUM_W'(acc_d[rd_ch_s]);
    case (rd_idx_s[7:6])
      2'b00:   rd_val_s = (rd_idx_s[5:0] == 6'd1) ? status_s : 32'd0;
      2'b10:   rd_val_s = rd_ch_ok_s ? acc_ext_s[31:0] : 32'd0;
      2'b11:   rd_val_s = rd_ch_ok_s ? {16'd0, cnt_d[rd_ch_s]} : 32'd0;
      default: rd_val_s = 32'd0;
    endcase
  end

  // Bus-side registers: data-phase capture, wait state and read data.
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= 8'd0;
      hready_o_q <= 1'b1;
      hrdata_q   <= 32'd0;
    end else begin
      if (bus.hready_i) begin
        dp_valid_q <= addr_ok_s;
        dp_write_q <= bus.hwrite;
        dp_idx_q   <= bus.haddr[9:2];
      end
      hready_o_q <= ~wait_s;
      hrdata_q   <= rd_load_s ? rd_val_s : 32'd0;
    end
  end

  // Pipeline and per-channel result state.
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_bad_q   <= 1'b0;
      s1_ch_q    <= '0;
      s1_log_q   <= 32'sd0;
      err_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= 16'd0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_bad_q   <= s1_bad_d;
      s1_ch_q    <= s1_ch_d;
      s1_log_q   <= s1_log_d;
      err_q      <= err_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.hready_o = hready_o_q;
  assign bus.hrdata   = hrdata_q;
  assign bus.hresp    = 1'b0;
endmodule

// File: tb/tb_ahb_log_acc.sv
// Directed bench for ahb_log_acc: read expectations are queued at address
// phase and compared when the read data phase completes.
module tb_ahb_log_acc;
  logic hclk;
  logic rst_n;
  ahb_log_acc_if bus ();

  ahb_log_acc #(.NCH(4), .FRAC(16), .ACC_W(24)) dut (
    .hclk  (hclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.hready_i = bus.hready_o;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int          errors = 0;
  int          checks = 0;
  int          last_waits = 0;
  bit          pend_rd = 1'b0;
  logic [31:0] pend_wdata = 32'd0;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One address phase; also completes the data phase of the previous transfer.
  task automatic issue(input bit v, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd);
    logic rdy;
    bus.hsel   = v;
    bus.htrans = v ? 2'b10 : 2'b00;
    bus.hwrite = w;
    bus.haddr  = a;
    bus.hwdata = pend_wdata;
    if (v && !w) exp_q.push_back(exp_rd);
    last_waits = 0;
    do begin
      @(negedge hclk);
      rdy = bus.hready_o;
      if (!rdy) last_waits++;
      else if (pend_rd) chk("rdata", bus.hrdata, exp_q.pop_front());
      else chk("idle_rdata", bus.hrdata, 32'd0);
      @(posedge hclk);
      #1;
    end while (!rdy && last_waits < 8);
    if (!rdy) chk("wait_timeout", {31'd0, rdy}, 32'd1);
    pend_rd    = v && !w;
    pend_wdata = wd;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    issue(1'b1, 1'b1, a, d, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] expv);
    issue(1'b1, 1'b0, a, 32'd0, expv);
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.haddr  = 32'd0;
    bus.hwdata = 32'd0;
    #12;
    chk("rst_hready", {31'd0, bus.hready_o}, 32'd1);
    chk("rst_hrdata", bus.hrdata, 32'd0);
    chk("rst_hresp", {31'd0, bus.hresp}, 32'd0);
    @(negedge hclk);
    rst_n = 1'b1;
    @(posedge hclk);
    #1;

    // first transfer after reset: no wait, status clear
    rd(32'h004, 32'h0000_0000);
    idle();
    chk("first_no_wait", 32'(last_waits), 32'd0);

    // ten samples of 0.5 -> -10.0
    for (int i = 0; i < 10; i++) wr(32'h100, 32'h3F00_0000);
    rd(32'h200, 32'hFFF6_0000);
    rd(32'h300, 32'd10);
    // ten more without clear -> -20.0, then clear
    for (int i = 0; i < 10; i++) wr(32'h100, 32'h3F00_0000);
    rd(32'h200, 32'hFFEC_0000);
    rd(32'h300, 32'd20);
    wr(32'h000, 32'h0000_0001);
    rd(32'h200, 32'h0000_0000);
    rd(32'h300, 32'h0000_0000);
    idle();

    // write followed immediately by read of the same channel: one wait state
    wr(32'h104, 32'h4000_0000);
    rd(32'h204, 32'h0001_0000);
    idle();
    chk("one_wait", 32'(last_waits), 32'd1);

    // invalid floats: zero, negative, infinity
    wr(32'h108, 32'h0000_0000);
    wr(32'h108, 32'hBF80_0000);
    wr(32'h108, 32'h7F80_0000);
    rd(32'h208, 32'h0000_0000);
    rd(32'h308, 32'h0000_0000);
    rd(32'h004, 32'h0004_0000);
    rd(32'h204, 32'h0001_0000);
    rd(32'h304, 32'd1);
    idle();

    // saturation at the 24-bit maximum
    for (int i = 0; i < 4; i++) wr(32'h10C, 32'h7F00_0000);
    rd(32'h20C, 32'h007F_FFFF);
    rd(32'h30C, 32'd4);
    // unmapped, out-of-range channel, DATA reads and ignored writes
    rd(32'h110, 32'h0000_0000);
    rd(32'h210, 32'h0000_0000);
    rd(32'h3FC, 32'h0000_0000);
    wr(32'h20C, 32'h1234_5678);
    wr(32'h004, 32'hFFFF_FFFF);
    rd(32'h20C, 32'h007F_FFFF);
    rd(32'h004, 32'h0004_0000);
    idle();

    // clear wipes error bits; a sample right after clear is kept
    wr(32'h000, 32'h0000_0001);
    rd(32'h004, 32'h0000_0000);
    rd(32'h30C, 32'h0000_0000);
    wr(32'h000, 32'h0000_0001);
    wr(32'h100, 32'h4000_0000);
    rd(32'h200, 32'h0001_0000);
    rd(32'h300, 32'd1);
    idle();

    // reset asserted mid-burst while a read is stalled
    wr(32'h100, 32'h4000_0000);
    wr(32'h100, 32'h4000_0000);
    bus.hsel   = 1'b1;
    bus.htrans = 2'b10;
    bus.hwrite = 1'b0;
    bus.haddr  = 32'h200;
    bus.hwdata = pend_wdata;
    @(posedge hclk);
    #1;
    chk("stall_before_rst", {31'd0, bus.hready_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_abort_hready", {31'd0, bus.hready_o}, 32'd1);
    chk("rst_abort_hrdata", bus.hrdata, 32'd0);
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.haddr  = 32'd0;
    bus.hwdata = 32'd0;
    pend_rd    = 1'b0;
    pend_wdata = 32'd0;
    exp_q.delete();
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    rst_n = 1'b1;
    @(posedge hclk);
    #1;
    rd(32'h200, 32'h0000_0000);
    rd(32'h300, 32'h0000_0000);
    rd(32'h004, 32'h0000_0000);
    rd(32'h20C, 32'h0000_0000);
    repeat (3) idle();
    rd(32'h200, 32'h0000_0000);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
